// File: rtl/common.sv
// Shared scalar types and default sizing for the commit stage.
// Holds the commit-trace depth default used by wb_commit.
package common;

  localparam int TRACE_DEPTH_DFLT = 4;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  typedef logic [4:0]  creg_addr_t;

endpackage

// File: rtl/pipes.sv
// Inter-stage bundles: writeback -> commit, and commit -> trace.
// commit_trace_t is the difftest beat format.
package pipes;

  import common::*;

  typedef struct packed {
    logic regwrite;
  } ctl_t;

  typedef struct packed {
    logic       valid;
    u64         pc;
    u32         raw_instr;
    creg_addr_t dst;
    ctl_t       ctl;
    u64         writedata;
    logic [7:0] excep;
  } writeback_data_t;

  typedef struct packed {
    u64         pc;
    u32         instr;
    logic       wen;
    creg_addr_t wdest;
    u64         wdata;
  } commit_trace_t;

endpackage

// File: rtl/regfile.sv
// 31x64 GPR file: x0 hardwired to zero, 2 comb read ports with write bypass.
// Ports: clk, reset_n, we/waddr/wdata write port, ra1/ra2 -> rd1/rd2.
module regfile
  import common::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       we,
  input  creg_addr_t waddr,
  input  u64         wdata,
  input  creg_addr_t ra1,
  input  creg_addr_t ra2,
  output u64         rd1,
  output u64         rd2
);

  u64 gpr_q [1:31];
  u64 gpr_d [1:31];

  always_comb begin
    gpr_d = gpr_q;
    for (int i = 1; i < 32; i++) begin
      if (we && waddr == 5'(i)) gpr_d[i] = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < 32; i++) gpr_q[i] <= '0;
    end else begin
      gpr_q <= gpr_d;
    end
  end

  // we already excludes x0, so a matching address is never zero
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < 32; i++) begin
      if (ra1 == 5'(i)) rd1 = gpr_q[i];
      if (ra2 == 5'(i)) rd2 = gpr_q[i];
    end
    if (we && ra1 == waddr) rd1 = wdata;
    if (we && ra2 == waddr) rd2 = wdata;
  end

endmodule

// File: rtl/wb_commit.sv
// Commit stage: retires writeback, writes GPRs, queues difftest trace beats.
// Ports: dataW in, ra1/ra2 -> rd1/rd2, stall, trace valid/ready/data, retire_count.
module wb_commit
  import common::*;
  import pipes::*;
#(
  parameter int TRACE_DEPTH = TRACE_DEPTH_DFLT
)
(
  input  logic            clk,
  input  logic            reset_n,
  input  writeback_data_t dataW,
  input  creg_addr_t      ra1,
  input  creg_addr_t      ra2,
  output u64              rd1,
  output u64              rd2,
  output logic            stall,
  output logic            trace_valid,
  input  logic            trace_ready,
  output commit_trace_t   trace,
  output u64              retire_count
);

  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  u64            retire_q, retire_d;

  commit_trace_t mem_q [TRACE_DEPTH];
  commit_trace_t push_e;

  logic commit;
  logic wen;
  logic pop;

  // stall comes from registered count only, never from trace_ready
  always_comb begin
    stall  = cnt_q == CW'(TRACE_DEPTH);
    commit = dataW.valid && dataW.excep == '0 && !stall;
    wen    = commit && dataW.ctl.regwrite
             && dataW.dst != '0;

    push_e       = '0;
    push_e.pc    = dataW.pc;
    push_e.instr = dataW.raw_instr;
    push_e.wen   = wen;
    push_e.wdest = wen ? dataW.dst : '0;
    push_e.wdata = wen ? dataW.writedata : '0;

    trace_valid = cnt_q != '0;
    pop         = trace_valid && trace_ready;

    wr_ptr_d = wr_ptr_q + PW'(commit);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(commit) - CW'(pop);
    retire_d = retire_q + 64'(commit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      retire_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      retire_q <= retire_d;
    end
  end

  // payload needs no reset; it is masked while empty
  always_ff @(posedge clk) begin
    if (commit) mem_q[wr_ptr_q] <= push_e;
  end

  assign trace        = trace_valid ? mem_q[rd_ptr_q] : '0;
  assign retire_count = retire_q;

  regfile u_rf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wen),
    .waddr   (dataW.dst),
    .wdata   (dataW.writedata),
    .ra1     (ra1),
    .ra2     (ra2),
    .rd1     (rd1),
    .rd2     (rd2)
  );

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: queue/array reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_commit;
  import common::*;
  import pipes::*;

  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  writeback_data_t dataW;
  creg_addr_t      ra1, ra2;
  u64              rd1, rd2;
  logic            stall;
  logic            trace_valid;
  logic            trace_ready;
  commit_trace_t   trace;
  u64              retire_count;

  wb_commit #(.TRACE_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dataW        (dataW),
    .ra1          (ra1),
    .ra2          (ra2),
    .rd1          (rd1),
    .rd2          (rd2),
    .stall        (stall),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace        (trace),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm,
                     input logic [191:0] act,
                     input logic [191:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // reference model
  commit_trace_t q[$];
  u64            gpr [32];
  u64            m_retire = 0;
  bit            mc, mp, mw;
  commit_trace_t me;

  initial for (int i = 0; i < 32; i++) gpr[i] = '0;

  always @(negedge reset_n) begin
    q.delete();
    for (int i = 0; i < 32; i++) gpr[i] = '0;
    m_retire = 0;
  end

  function automatic u64 m_rd(input creg_addr_t a);
    bit c;
    c = dataW.valid && dataW.excep == 0 && q.size() < DEPTH;
    if (a == 0) return '0;
    if (c && dataW.ctl.regwrite && a == dataW.dst)
      return dataW.writedata;
    return gpr[a];
  endfunction

  always @(posedge clk) begin
    if (reset_n === 1'b1) begin
      mc = dataW.valid && dataW.excep == 0 && q.size() < DEPTH;
      mp = q.size() != 0 && trace_ready;
      if (mp) void'(q.pop_front());
      if (mc) begin
        mw = dataW.ctl.regwrite && dataW.dst != 0;
        me.pc    = dataW.pc;
        me.instr = dataW.raw_instr;
        me.wen   = mw;
        me.wdest = mw ? dataW.dst : 5'd0;
        me.wdata = mw ? dataW.writedata : 64'd0;
        q.push_back(me);
        if (mw) gpr[dataW.dst] = dataW.writedata;
        m_retire = m_retire + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("stall", stall, q.size() == DEPTH);
    chk("trace_valid", trace_valid, q.size() != 0);
    if (q.size() != 0) chk("trace", trace, q[0]);
    chk("retire_count", retire_count, m_retire);
    chk("rd1", rd1, m_rd(ra1));
    chk("rd2", rd2, m_rd(ra2));
  end

  task automatic put(input bit v, input u64 pc, input u32 ins,
                     input creg_addr_t d, input bit rw,
                     input u64 wd, input logic [7:0] ex);
    @(posedge clk);
    #1;
    dataW.valid        = v;
    dataW.pc           = pc;
    dataW.raw_instr    = ins;
    dataW.dst          = d;
    dataW.ctl.regwrite = rw;
    dataW.writedata    = wd;
    dataW.excep        = ex;
  endtask

  task automatic idle();
    put(0, '0, '0, '0, 0, '0, '0);
  endtask

  task automatic drain(input int n);
    trace_ready = 1;
    repeat (n) @(posedge clk);
    #1 trace_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset_n = 0;
    dataW = '0;
    ra1 = 0;
    ra2 = 0;
    trace_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    chk("rst_tvalid", trace_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_retire", retire_count, 0);

    // bypass then storage read
    ra1 = 5;
    put(1, 64'h1000, 32'h0050_0293, 5, 1, 64'hDEAD_BEEF, 0);
    @(negedge clk);
    chk("bypass_rd1", rd1, 64'hDEAD_BEEF);
    idle();
    @(negedge clk);
    chk("stored_rd1", rd1, 64'hDEAD_BEEF);
    chk("trace_first", trace,
        {64'h1000, 32'h0050_0293, 1'b1, 5'd5, 64'hDEAD_BEEF});
    chk("retire_1", retire_count, 1);

    // write to x0, with simultaneous pop of the previous beat
    trace_ready = 1;
    ra2 = 0;
    put(1, 64'h1004, 32'h0000_0013, 0, 1, 64'h1234, 0);
    @(negedge clk);
    chk("x0_rd2", rd2, 0);
    idle();
    trace_ready = 0;
    @(negedge clk);
    chk("trace_x0", trace,
        {64'h1004, 32'h0000_0013, 1'b0, 5'd0, 64'd0});
    chk("retire_2", retire_count, 2);
    drain(1);

    // fill to full, fifth held
    for (int i = 0; i < 5; i++)
      put(1, 64'h2000 + 64'(4 * i), 32'h13,
          5'(i + 1), 1, 64'hA0 + 64'(i), 0);
    @(negedge clk);
    chk("full_stall", stall, 1);
    chk("full_retire", retire_count, 6);
    @(posedge clk);
    @(negedge clk);
    chk("held_nowrite", rd1, 64'hDEAD_BEEF);
    @(posedge clk);
    #1 trace_ready = 1;
    @(posedge clk);
    #1 trace_ready = 0;
    @(negedge clk);
    chk("unstall", stall, 0);
    chk("held_retire", retire_count, 6);
    idle();
    @(negedge clk);
    chk("late_retire", retire_count, 7);
    chk("late_write", rd1, 64'hA4);
    drain(5);

    // exception never commits
    ra1 = 7;
    put(1, 64'h3000, 32'h13, 7, 1, 64'h77, 0);
    put(1, 64'h3004, 32'h13, 7, 1, 64'hBAD, 8'h1);
    @(negedge clk);
    chk("excep_nobyp", rd1, 64'h77);
    idle();
    @(negedge clk);
    chk("excep_gpr", rd1, 64'h77);
    chk("excep_retire", retire_count, 8);
    chk("excep_trace", trace.pc, 64'h3000);
    drain(2);

    // steady push+pop across pointer wrap
    put(1, 64'h4000, 32'h13, 10, 1, 64'h400, 0);
    put(1, 64'h4004, 32'h13, 11, 1, 64'h401, 0);
    for (int k = 2; k < 12; k++) begin
      put(1, 64'h4000 + 64'(4 * k), 32'h13,
          5'(10 + k), 1, 64'h400 + 64'(k), 0);
      trace_ready = 1;
    end
    idle();
    trace_ready = 0;
    @(negedge clk);
    chk("wrap_head", trace.pc, 64'h4028);
    chk("wrap_retire", retire_count, 20);
    drain(3);

    // async reset mid-operation
    for (int i = 0; i < 3; i++)
      put(1, 64'h4100 + 64'(4 * i), 32'h13,
          5'(i + 1), 1, 64'h11 * 64'(i + 1), 0);
    idle();
    ra1 = 1;
    ra2 = 2;
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("arst_tvalid", trace_valid, 0);
    chk("arst_rd1", rd1, 0);
    chk("arst_rd2", rd2, 0);
    chk("arst_stall", stall, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    chk("post_rst_tvalid", trace_valid, 0);
    put(1, 64'h5000, 32'h13, 9, 1, 64'h99, 0);
    idle();
    @(negedge clk);
    chk("post_rst_trace", trace.pc, 64'h5000);
    chk("post_rst_retire", retire_count, 1);
    drain(2);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 Parameter TRACE_DEPTH, default 4, gives the commit-trace FIFO entries and SHALL be a power of two, at least 2.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 dataW  in  writeback_data_t  retiring instruction from writeback. Uses fields valid, pc, raw_instr, dst, ctl.regwrite, writedata and excep.
REQ-005 ra1, ra2  in  creg_addr_t (5)  decode-stage GPR read addresses.
REQ-006 rd1, rd2  out  u64  GPR read data.
REQ-007 stall  out  1  commit blocked; upstream SHALL hold dataW unchanged while stall is high.
REQ-008 trace_valid  out  1, trace_ready  in  1  commit-trace handshake toward the difftest consumer.
REQ-009 trace  out  commit_trace_t  {pc u64, instr u32, wen 1, wdest 5, wdata u64}, the FIFO head entry.
REQ-010 retire_count  out  u64  number of committed instructions.

Function
REQ-011 Retire condition: commit = dataW.valid && (dataW.excep == 0) && !stall.
- An instruction with an exception SHALL never commit, write a GPR or be traced.
REQ-012 stall SHALL equal (fifo_count == TRACE_DEPTH), registered state only. It SHALL NOT depend on trace_ready in the same cycle.
REQ-013 On commit, wen = ctl.regwrite && (dst != 0).
- When wen is 1, GPR[dst] <= writedata at the clock edge.
- Writes to x0 SHALL be dropped.
REQ-014 A write SHALL NOT occur in a cycle without commit, even if regwrite is 1.
REQ-015 Read ports are combinational.
- rdN = 0 when raN == 0.
- Otherwise, if commit && wen && (raN == dst), rdN = writedata (same-cycle write bypass).
- Otherwise rdN = GPR[raN].
REQ-016 On commit, the FIFO SHALL push {pc, raw_instr[31:0], wen, wen ? dst : 0, wen ? writedata : 0}.
REQ-017 trace_valid = (fifo_count != 0); trace shows the oldest entry.
- Pop SHALL occur when trace_valid && trace_ready.
REQ-018 Push and pop in the same cycle:
- count SHALL be unchanged.
- Both pointers advance modulo TRACE_DEPTH.
- This is legal only when not full, since push is already gated by stall.
REQ-019 When full with trace_ready=1:
- The pop occurs and stall deasserts in the next cycle.
- The instruction held that cycle commits one cycle later.
REQ-020 trace SHALL hold stable while trace_valid && !trace_ready.
REQ-021 retire_count SHALL increment by 1 on each commit and wrap at 2^64.
REQ-022 Pointers are log2(TRACE_DEPTH) bits and wrap naturally. count is log2(TRACE_DEPTH)+1 bits.

Reset
REQ-023 While reset_n is low, the following SHALL clear asynchronously: GPR[1..31]=0, read/write pointers=0, fifo_count=0, retire_count=0.
- Consequently trace_valid=0 and stall=0.
REQ-024 Reset asserted mid-operation SHALL discard all FIFO entries.
- No trace beat SHALL be presented until a new commit after reset_n rises.
REQ-025 FIFO payload storage need not be reset; it SHALL be unobservable while trace_valid=0.

Structure
REQ-026 commit_trace_t SHALL live in package pipes. The TRACE_DEPTH default constant SHALL live in package common.
REQ-027 The 31x64 GPR array with two read ports, one write port and bypass SHALL be a sub-module named regfile. The trace FIFO SHALL stay inline in wb_commit.
REQ-028 No combinational path SHALL run from trace_ready to stall.

Verification
REQ-029 Reset, then commit dst=5, regwrite=1, writedata=0xDEAD_BEEF with ra1=5 in the same cycle.
- rd1=0xDEADBEEF via bypass; next cycle rd1=0xDEADBEEF from storage.
- trace={pc, instr, 1, 5, 0xDEADBEEF}; retire_count=1.
REQ-030 Commit dst=0, writedata=0x1234.
- rd with ra=0 stays 0.
- Traced entry has wen=0, wdest=0, wdata=0.
REQ-031 Hold trace_ready=0 and commit 5 instructions with DEPTH=4.
- stall rises after the 4th commit.
- The 5th is held, with no GPR write and retire_count=4.
- Raise trace_ready for one cycle: pop occurs, the 5th commits the following cycle, and retire_count=5.
REQ-032 Present excep!=0 with valid=1, regwrite=1, dst=7.
- GPR[7] is unchanged, no FIFO push, retire_count is unchanged.
REQ-033 With 2 entries queued, trace_ready=1 and a commit every cycle for 10 cycles.
- count holds at 2 and trace order matches commit order across pointer wrap.
REQ-034 Assert reset_n low asynchronously between edges with 3 entries queued.
- trace_valid drops immediately and all GPRs read 0.
- After release, the first trace is the first new commit.
